alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one clock, and reset SHALL be asynchronous and active-low.
REQ-002 Port clk, input, 1: rising-edge clock for all state.
REQ-003 Port rst_n, input, 1: asynchronous active-low reset.
REQ-004 Ports req_valid_0 and req_valid_1, input, 1 each: requester 0/1 presents an operation.
REQ-005 Ports req_ready_0 and req_ready_1, output, 1 each: operation accepted in the cycle where valid and ready are both high.
REQ-006 Ports req_a_0, req_b_0, req_a_1 and req_b_1, input, 8 each: operands; a is the sole operand for one-operand ops.
REQ-007 Ports req_op_0 and req_op_1, input, 4 each: ALU function code using the shared OP_* codes.
REQ-008 Ports rsp_valid_0 and rsp_valid_1, output, 1 each: result ready for requester 0/1.
REQ-009 Ports rsp_ready_0 and rsp_ready_1, input, 1 each: requester consumes the result.
REQ-010 Port rsp_data, output, 8: registered ALU result, shared by both requesters.
REQ-011 Port rsp_flags, output, 5: registered flags {zero, negative, carry, overflow, parity}.
REQ-012 Port busy, output, 1: high whenever state is not IDLE.

Function
REQ-013 The block SHALL share one ALU instance between the two requesters using an FSM with states IDLE, EXEC and RESP.
REQ-014 In IDLE, req_ready_g SHALL be asserted only for the granted port g, and only if req_valid_g is high; req_ready SHALL be 0 in EXEC and RESP.
REQ-015 Grant SHALL be round-robin: if only one port is valid, that port wins; if both are valid, the port other than last_grant wins.
REQ-016 last_grant SHALL reset to 1, so port 0 wins the first contention.
REQ-017 On acceptance, operands, op and grant id SHALL be registered, and the FSM SHALL move IDLE->EXEC.
REQ-018 In EXEC, the ALU SHALL be driven only from the registered operands; rsp_data and rsp_flags SHALL be captured; the FSM SHALL move EXEC->RESP.
REQ-019 In RESP, rsp_valid_g SHALL be high for the granted port only; rsp_data and rsp_flags SHALL be held stable.
REQ-020 On rsp_ready_g, the FSM SHALL move RESP->IDLE and last_grant SHALL become g.
REQ-021 rsp_ready on the non-granted port SHALL be ignored.
REQ-022 Latency SHALL be: accept at cycle N, rsp_valid at N+2; minimum issue interval is 3 cycles.
REQ-023 carry SHALL be the 9th bit of a+b for OP_SUM and SHALL be 0 for all other ops.
REQ-024 overflow SHALL be the ALU signed overflow for OP_SUM and OP_SUB and SHALL be 0 for all other ops.
REQ-025 zero, negative and parity SHALL be derived from the 8-bit result for every op.
REQ-026 An undefined op code SHALL complete normally with rsp_data=0x00 and zero=1.
REQ-027 Requesters SHALL hold req_* stable while valid and not ready; the block SHALL sample operands only in the accept cycle.
REQ-028 No combinational path SHALL exist from rsp_ready_* to req_ready_*.

Reset
REQ-029 On rst_n low, the block SHALL asynchronously set state=IDLE, last_grant=1, rsp_valid_*=0, req_ready_*=0, busy=0, rsp_data=0x00 and rsp_flags=0.
REQ-030 Reset during EXEC or RESP SHALL discard the in-flight operation with no response issued after rst_n rises.

Structure
REQ-031 OP_* codes, the flag bit positions and the FSM state encodings SHALL reside in the shared constants include.
REQ-032 The block SHALL instantiate exactly one existing alu sub-module and SHALL not duplicate ALU logic.

Verification
REQ-033 Port 0 issues OP_SUM 0x7F+0x01 accepted at cycle N -> rsp_valid_0 at N+2, rsp_data=0x80, negative=1, overflow=1, carry=0, zero=0.
REQ-034 Port 1 issues OP_SUM 0xFF+0x01 -> rsp_data=0x00, zero=1, carry=1, overflow=0, and rsp_valid_0 stays 0.
REQ-035 Both ports hold valid continuously from reset with rsp_ready tied high -> grants are 0,1,0,1, with accepts spaced exactly 3 cycles.
REQ-036 Port 0 does OP_AND 0xF0,0x3C, then holds rsp_ready_0 low for 5 cycles -> rsp_data=0x30 stable, rsp_valid_0 held, and req_ready_1=0 throughout.
REQ-037 rst_n is pulsed low during EXEC -> all outputs return to reset values immediately, no rsp_valid after release, and a subsequent contention grants port 0.
REQ-038 Undefined op 4'hF with a=0x55 -> rsp_data=0x00, rsp_flags: zero=1 and all other flags 0.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the two-port ALU arbiter: op codes, flag bit positions
// and FSM state encodings.
package alu_arbiter_pkg;

    localparam int DATA_W = 8;
    localparam int FLAG_W = 5;

    localparam logic [3:0] OP_SUM = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_NOT = 4'h5;
    localparam logic [3:0] OP_SHL = 4'h6;
    localparam logic [3:0] OP_SHR = 4'h7;

    // rsp_flags layout is {zero, negative, carry, overflow, parity}
    localparam int FLAG_ZERO  = 4;
    localparam int FLAG_NEG   = 3;
    localparam int FLAG_CARRY = 2;
    localparam int FLAG_OVF   = 1;
    localparam int FLAG_PAR   = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational 8-bit ALU with flag generation; undefined op codes
// produce a zero result.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  logic [3:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o,
    output logic [FLAG_W-1:0] flags_o
);

    logic [DATA_W:0] sum9;
    logic            carry;
    logic            ovf;

    always_comb begin
        sum9     = {1'b0, a_i} + {1'b0, b_i};
        result_o = '0;
        carry    = 1'b0;
        ovf      = 1'b0;
        case (op_i)
            OP_SUM: begin
                result_o = sum9[DATA_W-1:0];
                carry    = sum9[DATA_W];
                ovf      = (a_i[DATA_W-1] == b_i[DATA_W-1]) &&
                           (result_o[DATA_W-1] != a_i[DATA_W-1]);
            end
            OP_SUB: begin
                result_o = a_i - b_i;
                ovf      = (a_i[DATA_W-1] != b_i[DATA_W-1]) &&
                           (result_o[DATA_W-1] != a_i[DATA_W-1]);
            end
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_NOT:  result_o = ~a_i;
            OP_SHL:  result_o = {a_i[DATA_W-2:0], 1'b0};
            OP_SHR:  result_o = {1'b0, a_i[DATA_W-1:1]};
            default: result_o = '0;
        endcase

        flags_o             = '0;
        flags_o[FLAG_ZERO]  = (result_o == '0);
        flags_o[FLAG_NEG]   = result_o[DATA_W-1];
        flags_o[FLAG_CARRY] = carry;
        flags_o[FLAG_OVF]   = ovf;
        flags_o[FLAG_PAR]   = ^result_o;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU through an IDLE/EXEC/RESP FSM with
// round-robin grant; one operation is in flight at a time.
module alu_arbiter
    import alu_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_0,
    input  logic              req_valid_1,
    output logic              req_ready_0,
    output logic              req_ready_1,
    input  logic [DATA_W-1:0] req_a_0,
    input  logic [DATA_W-1:0] req_b_0,
    input  logic [DATA_W-1:0] req_a_1,
    input  logic [DATA_W-1:0] req_b_1,
    input  logic [3:0]        req_op_0,
    input  logic [3:0]        req_op_1,
    output logic              rsp_valid_0,
    output logic              rsp_valid_1,
    input  logic              rsp_ready_0,
    input  logic              rsp_ready_1,
    output logic [DATA_W-1:0] rsp_data,
    output logic [FLAG_W-1:0] rsp_flags,
    output logic              busy
);

    state_e            state_q;
    logic              gnt_q;
    logic              last_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [3:0]        op_q;
    logic [DATA_W-1:0] data_q;
    logic [FLAG_W-1:0] flags_q;
    logic              rsp_valid0_q;
    logic              rsp_valid1_q;

    logic              win;
    logic              accept;
    logic              rsp_take;
    logic [DATA_W-1:0] alu_res;
    logic [FLAG_W-1:0] alu_flags;

    // With both ports valid the one that did not win last time goes next.
    assign win         = (req_valid_0 && req_valid_1) ? ~last_q : req_valid_1;
    assign req_ready_0 = rst_n && (state_q == ST_IDLE) && req_valid_0 && !win;
    assign req_ready_1 = rst_n && (state_q == ST_IDLE) && req_valid_1 && win;
    assign accept      = req_ready_0 || req_ready_1;
    assign rsp_take    = gnt_q ? rsp_ready_1 : rsp_ready_0;

    assign busy        = (state_q != ST_IDLE);
    assign rsp_valid_0 = rsp_valid0_q;
    assign rsp_valid_1 = rsp_valid1_q;
    assign rsp_data    = data_q;
    assign rsp_flags   = flags_q;

    alu_arbiter_alu u_alu (
        .op_i     (op_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .result_o (alu_res),
        .flags_o  (alu_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            gnt_q        <= 1'b0;
            last_q       <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            data_q       <= '0;
            flags_q      <= '0;
            rsp_valid0_q <= 1'b0;
            rsp_valid1_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        gnt_q   <= win;
                        a_q     <= win ? req_a_1  : req_a_0;
                        b_q     <= win ? req_b_1  : req_b_0;
                        op_q    <= win ? req_op_1 : req_op_0;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    data_q       <= alu_res;
                    flags_q      <= alu_flags;
                    rsp_valid0_q <= !gnt_q;
                    rsp_valid1_q <= gnt_q;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_take) begin
                        rsp_valid0_q <= 1'b0;
                        rsp_valid1_q <= 1'b0;
                        last_q       <= gnt_q;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a transaction-level model checked every
// cycle, plus literal expectations on selected responses.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid_0, req_valid_1;
    logic       req_ready_0, req_ready_1;
    logic [7:0] req_a_0, req_b_0, req_a_1, req_b_1;
    logic [3:0] req_op_0, req_op_1;
    logic       rsp_valid_0, rsp_valid_1;
    logic       rsp_ready_0, rsp_ready_1;
    logic [7:0] rsp_data;
    logic [4:0] rsp_flags;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .req_a_0(req_a_0), .req_b_0(req_b_0),
        .req_a_1(req_a_1), .req_b_1(req_b_1),
        .req_op_0(req_op_0), .req_op_1(req_op_1),
        .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
        .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Result and flags from plain integer arithmetic: {result, z, n, c, v, p}
    function automatic logic [12:0] model_alu(input logic [3:0] op, input logic [7:0] a,
                                              input logic [7:0] b);
        int ua, ub, sa, sb, t;
        logic [7:0] r;
        bit c, v;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        t = 0; c = 0; v = 0; r = 8'h00;
        case (op)
            OP_SUM: begin t = ua + ub; r = t[7:0]; c = (t > 255);
                          v = (sa + sb > 127) || (sa + sb < -128); end
            OP_SUB: begin t = ua - ub; r = t[7:0];
                          v = (sa - sb > 127) || (sa - sb < -128); end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_NOT: r = ~a;
            OP_SHL: begin t = ua * 2; r = t[7:0]; end
            OP_SHR: begin t = ua / 2; r = t[7:0]; end
            default: r = 8'h00;
        endcase
        return {r, (r == 8'h00), r[7], c, v, ^r};
    endfunction

    // Transaction model: one outstanding op, response due two cycles after accept.
    bit         m_busy = 0;
    bit         m_last = 1;
    bit         m_gnt  = 0;
    int         m_acc  = 0;
    logic [12:0] m_exp;

    always @(negedge clk) begin
        bit e0, e1, due;
        if (!rst_n) begin
            chk("rst req_ready_0", req_ready_0, 0);
            chk("rst req_ready_1", req_ready_1, 0);
            chk("rst rsp_valid_0", rsp_valid_0, 0);
            chk("rst rsp_valid_1", rsp_valid_1, 0);
            chk("rst busy", busy, 0);
            chk("rst rsp_data", rsp_data, 0);
            chk("rst rsp_flags", rsp_flags, 0);
            m_busy = 0;
            m_last = 1;
        end else if (!m_busy) begin
            e0 = req_valid_0 && (!req_valid_1 || m_last == 1);
            e1 = req_valid_1 && (!req_valid_0 || m_last == 0);
            chk("idle req_ready_0", req_ready_0, e0);
            chk("idle req_ready_1", req_ready_1, e1);
            chk("idle rsp_valid_0", rsp_valid_0, 0);
            chk("idle rsp_valid_1", rsp_valid_1, 0);
            chk("idle busy", busy, 0);
            if (e0 || e1) begin
                m_busy = 1;
                m_gnt  = e1;
                m_acc  = cyc;
                m_exp  = e1 ? model_alu(req_op_1, req_a_1, req_b_1)
                            : model_alu(req_op_0, req_a_0, req_b_0);
            end
        end else begin
            due = (cyc >= m_acc + 2);
            chk("busy req_ready_0", req_ready_0, 0);
            chk("busy req_ready_1", req_ready_1, 0);
            chk("busy busy", busy, 1);
            chk("model rsp_valid_0", rsp_valid_0, due && !m_gnt);
            chk("model rsp_valid_1", rsp_valid_1, due && m_gnt);
            if (due) begin
                chk("model rsp_data", rsp_data, m_exp[12:5]);
                chk("model rsp_flags", rsp_flags, m_exp[4:0]);
                if (m_gnt ? rsp_ready_1 : rsp_ready_0) begin
                    m_busy = 0;
                    m_last = m_gnt;
                end
            end
        end
    end

    task automatic issue(input int p, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, output int acc);
        bit got;
        got = 0;
        acc = -100;
        @(posedge clk); #1;
        if (p == 0) begin req_op_0 = op; req_a_0 = a; req_b_0 = b; req_valid_0 = 1; end
        else        begin req_op_1 = op; req_a_1 = a; req_b_1 = b; req_valid_1 = 1; end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if ((p == 0 && req_ready_0) || (p == 1 && req_ready_1)) begin
                got = 1;
                acc = cyc;
            end
        end
        chk("issue accepted", got, 1);
        @(posedge clk); #1;
        if (p == 0) req_valid_0 = 0; else req_valid_1 = 0;
    endtask

    task automatic wait_rsp(input int p, input int acc, input logic [7:0] ed,
                            input logic [4:0] ef, input string nm);
        bit got;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (p == 1) chk({nm, " other rsp_valid_0"}, rsp_valid_0, 0);
            if ((p == 0 && rsp_valid_0) || (p == 1 && rsp_valid_1)) begin
                got = 1;
                chk({nm, " latency"}, cyc - acc, 2);
                chk({nm, " data"}, rsp_data, ed);
                chk({nm, " flags"}, rsp_flags, ef);
            end
        end
        chk({nm, " rsp seen"}, got, 1);
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 0;
        for (int i = 0; i < 20 && !idle; i++) begin
            @(negedge clk);
            if (!busy && !rsp_valid_0 && !rsp_valid_1) idle = 1;
        end
        chk("return to idle", idle, 1);
    endtask

    initial begin
        int acc;
        int gq[$];
        int cq[$];
        rst_n = 0;
        req_a_0 = 8'hAA; req_b_0 = 8'h0F; req_op_0 = OP_XOR;
        req_a_1 = 8'h80; req_b_1 = 8'h01; req_op_1 = OP_SUB;
        req_valid_0 = 1; req_valid_1 = 1;
        rsp_ready_0 = 1; rsp_ready_1 = 1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1;

        // Continuous contention from reset: alternate grants, 3-cycle spacing.
        for (int i = 0; i < 40 && gq.size() < 4; i++) begin
            @(negedge clk);
            if (req_valid_0 && req_ready_0) begin gq.push_back(0); cq.push_back(cyc); end
            if (req_valid_1 && req_ready_1) begin gq.push_back(1); cq.push_back(cyc); end
        end
        chk("rr grant count", gq.size(), 4);
        for (int i = 0; i < gq.size(); i++) chk("rr grant order", gq[i], i % 2);
        for (int i = 1; i < cq.size(); i++) chk("rr spacing", cq[i] - cq[i-1], 3);
        @(posedge clk); #1;
        req_valid_0 = 0; req_valid_1 = 0;
        wait_idle();

        issue(0, OP_SUM, 8'h7F, 8'h01, acc);
        wait_rsp(0, acc, 8'h80, 5'b01011, "sum 7f+01");
        wait_idle();

        issue(1, OP_SUM, 8'hFF, 8'h01, acc);
        wait_rsp(1, acc, 8'h00, 5'b10100, "sum ff+01");
        wait_idle();

        issue(0, 4'hF, 8'h55, 8'h00, acc);
        wait_rsp(0, acc, 8'h00, 5'b10000, "undef op");
        wait_idle();

        issue(1, OP_SUB, 8'h00, 8'h01, acc);
        wait_rsp(1, acc, 8'hFF, 5'b01000, "sub 00-01");
        wait_idle();

        // Response back-pressure while the other port waits.
        rsp_ready_0 = 0;
        req_op_1 = OP_OR; req_a_1 = 8'h01; req_b_1 = 8'h02; req_valid_1 = 1;
        issue(0, OP_AND, 8'hF0, 8'h3C, acc);
        wait_rsp(0, acc, 8'h30, 5'b00000, "and hold");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold rsp_valid_0", rsp_valid_0, 1);
            chk("hold rsp_data", rsp_data, 8'h30);
            chk("hold req_ready_1", req_ready_1, 0);
        end
        @(posedge clk); #1;
        rsp_ready_0 = 1;
        begin
            bit got1;
            got1 = 0;
            for (int i = 0; i < 10 && !got1; i++) begin
                @(negedge clk);
                if (req_ready_1) got1 = 1;
            end
            chk("port1 after hold", got1, 1);
        end
        @(posedge clk); #1;
        req_valid_1 = 0;
        wait_idle();

        // Reset pulse while an operation is executing.
        issue(0, OP_SUM, 8'h01, 8'h02, acc);
        #1 rst_n = 0;
        #1;
        chk("async rst busy", busy, 0);
        chk("async rst rsp_valid_0", rsp_valid_0, 0);
        chk("async rst rsp_data", rsp_data, 0);
        chk("async rst rsp_flags", rsp_flags, 0);
        @(posedge clk); #2;
        rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post rst rsp_valid_0", rsp_valid_0, 0);
            chk("post rst rsp_valid_1", rsp_valid_1, 0);
        end
        @(posedge clk); #1;
        req_op_0 = OP_NOT; req_a_0 = 8'h0F;
        req_op_1 = OP_SHL; req_a_1 = 8'h81;
        req_valid_0 = 1; req_valid_1 = 1;
        @(negedge clk);
        chk("post rst grant 0", req_ready_0, 1);
        chk("post rst grant 1", req_ready_1, 0);
        @(posedge clk); #1;
        req_valid_0 = 0; req_valid_1 = 0;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
